// File: rtl/bus_sram_slave.sv
// Word-organised SRAM behind a valid/ready request bus with byte/half/word lanes and range/alignment errors.
// Latency: WAIT+1 clock edges from the edge that samples valid to the one-cycle ready pulse.
// Backpressure: one request at a time; the master holds valid until ready, and dropping valid while waiting aborts.
module bus_sram_slave #(
    parameter int unsigned AW   = 8,
    parameter logic [31:0] BASE = 32'h0,
    parameter int unsigned WAIT = 1
) (
    input  logic        clk,
    input  logic        rstb,
    input  logic [31:0] addr,
    input  logic [2:0]  size,
    input  logic        valid,
    input  logic        write,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        busy
);

    localparam int unsigned DEPTH    = 1 << AW;
    localparam logic [3:0]  WAIT_CNT = 4'(WAIT);
    // Byte span of the array, kept wide so BASE + span never wraps in the compare.
    localparam logic [33:0] SPAN     = 34'd4 << AW;

    // State names are prefixed because WAIT is already the wait-cycle parameter.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t      state;
    logic [3:0]  cnt;

    // Captured request, used once the FSM has left IDLE.
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  size_q;
    logic        write_q;

    logic [31:0] mem [DEPTH];

    // Effective request: live inputs in IDLE (needed when WAIT=0), captured copy otherwise.
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_size;
    logic        req_write;

    logic [31:0] offset;
    logic        range_err;
    logic        align_err;
    logic        req_err;
    logic [AW-1:0] word_idx;
    logic [1:0]  lane;
    logic        commit;

    logic [3:0]  be;
    logic [31:0] wd_lanes;
    logic [31:0] rd_word;
    logic [31:0] rd_shift;
    logic [31:0] load_data;
    logic [31:0] resp_data;

    // Pick the request the response will be computed from.
    always_comb begin
        req_addr  = addr_q;
        req_wdata = wdata_q;
        req_size  = size_q;
        req_write = write_q;
        if (state == ST_IDLE) begin
            req_addr  = addr;
            req_wdata = wdata;
            req_size  = size;
            req_write = write;
        end
    end

    // Address decode and error classification.
    always_comb begin
        offset    = req_addr - BASE;
        range_err = (req_addr < BASE) || ({2'b00, offset} >= SPAN);
        align_err = 1'b0;
        case (req_size)
            3'd0:    align_err = 1'b0;
            3'd1:    align_err = req_addr[0];
            3'd2:    align_err = (req_addr[1:0] != 2'b00);
            default: align_err = 1'b1;
        endcase
        req_err  = range_err || align_err;
        // Truncation is safe: out-of-range offsets are already flagged as errors.
        word_idx = offset[AW+1:2];
        lane     = req_addr[1:0];
    end

    // The edge that enters RESP is the one that commits the access.
    always_comb begin
        commit = 1'b0;
        if (rstb) begin
            if (state == ST_IDLE && valid && WAIT_CNT == 4'd0) begin
                commit = 1'b1;
            end else if (state == ST_WAIT && valid && cnt == 4'd1) begin
                commit = 1'b1;
            end
        end
    end

    // Byte-lane enables and lane-replicated store data.
    always_comb begin
        be       = 4'b0000;
        wd_lanes = 32'h0;
        case (req_size)
            3'd0: begin
                be       = 4'b0001 << lane;
                wd_lanes = {4{req_wdata[7:0]}};
            end
            3'd1: begin
                be       = lane[1] ? 4'b1100 : 4'b0011;
                wd_lanes = {2{req_wdata[15:0]}};
            end
            3'd2: begin
                be       = 4'b1111;
                wd_lanes = req_wdata;
            end
            default: begin
                be       = 4'b0000;
                wd_lanes = 32'h0;
            end
        endcase
    end

    // Load path: align the addressed bytes to bit 0, then zero-extend to the access size.
    always_comb begin
        rd_word   = mem[word_idx];
        rd_shift  = rd_word >> {lane, 3'b000};
        load_data = 32'h0;
        case (req_size)
            3'd0:    load_data = {24'h0, rd_shift[7:0]};
            3'd1:    load_data = {16'h0, rd_shift[15:0]};
            3'd2:    load_data = rd_shift;
            default: load_data = 32'h0;
        endcase
        resp_data = (req_err || req_write) ? 32'h0 : load_data;
    end

    // Storage array: no reset, written only by a committed, error-free store.
    always_ff @(posedge clk) begin
        if (commit && req_write && !req_err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[word_idx][8*i +: 8] <= wd_lanes[8*i +: 8];
                end
            end
        end
    end

    // Request FSM with registered ready/err/busy/rdata.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state   <= ST_IDLE;
            cnt     <= 4'd0;
            ready   <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
            rdata   <= 32'h0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            size_q  <= 3'd0;
            write_q <= 1'b0;
        end else begin
            ready <= 1'b0;
            err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (valid) begin
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        size_q  <= size;
                        write_q <= write;
                        cnt     <= WAIT_CNT;
                        state   <= ST_WAIT;
                        busy    <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (!valid) begin
                        // Master abort: drop the request silently.
                        state <= ST_IDLE;
                        cnt   <= 4'd0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
            // Completing edge overrides the per-state moves above.
            if (commit) begin
                state <= ST_RESP;
                busy  <= 1'b1;
                ready <= 1'b1;
                err   <= req_err;
                rdata <= resp_data;
            end
        end
    end

endmodule

// File: tb/tb_bus_sram_slave.sv
// Directed bench for bus_sram_slave: a WAIT=1 instance for the vector table and corner sequences, a WAIT=0 instance for back-to-back traffic.
// Expected values are hand-computed constants in the table and sequences.
// The bench drives one request at a time and holds valid until ready.
module tb_bus_sram_slave;

    logic        clk;
    logic        rstb;
    logic [31:0] addr;
    logic [2:0]  size;
    logic        write;
    logic [31:0] wdata;

    logic        valid1, ready1, err1, busy1;
    logic [31:0] rdata1;
    logic        valid0, ready0, err0, busy0;
    logic [31:0] rdata0;

    int checks = 0;
    int errors = 0;

    bus_sram_slave #(.AW(8), .BASE(32'h0), .WAIT(1)) dut1 (
        .clk(clk), .rstb(rstb), .addr(addr), .size(size), .valid(valid1),
        .write(write), .wdata(wdata), .rdata(rdata1), .ready(ready1),
        .err(err1), .busy(busy1)
    );

    bus_sram_slave #(.AW(8), .BASE(32'h0), .WAIT(0)) dut0 (
        .clk(clk), .rstb(rstb), .addr(addr), .size(size), .valid(valid0),
        .write(write), .wdata(wdata), .rdata(rdata0), .ready(ready0),
        .err(err0), .busy(busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [2:0]  sz;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    localparam int NV = 23;
    vec_t vt [NV];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Issue one request at posedge+1, wait (bounded) for ready, check latency and pulse width.
    task automatic do_req(input bit use0, input logic wr, input logic [2:0] sz,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er);
        int lat;
        bit got;
        addr  = a;
        size  = sz;
        write = wr;
        wdata = wd;
        if (use0) valid0 = 1'b1;
        else      valid1 = 1'b1;
        lat = 0;
        got = 1'b0;
        rd  = 32'h0;
        er  = 1'b0;
        while (!got && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (use0 ? ready0 : ready1) begin
                got = 1'b1;
                rd  = use0 ? rdata0 : rdata1;
                er  = use0 ? err0 : err1;
            end
        end
        valid0 = 1'b0;
        valid1 = 1'b0;
        check("latency", 32'(lat), use0 ? 32'd1 : 32'd2);
        @(posedge clk);
        #1;
        check("ready_pulse", {31'h0, use0 ? ready0 : ready1}, 32'h0);
    endtask

    logic [31:0] rd;
    logic        er;
    logic [31:0] fa, fb, fk;
    int          nready;
    int          iters;

    initial begin
        vt[0]  = '{1'b1, 3'd2, 32'h010, 32'hDEADBEEF, 32'h00000000, 1'b0};
        vt[1]  = '{1'b0, 3'd2, 32'h010, 32'h0,        32'hDEADBEEF, 1'b0};
        vt[2]  = '{1'b1, 3'd0, 32'h013, 32'hFFFFFF5A, 32'h00000000, 1'b0};
        vt[3]  = '{1'b0, 3'd2, 32'h010, 32'h0,        32'h5AADBEEF, 1'b0};
        vt[4]  = '{1'b0, 3'd0, 32'h013, 32'h0,        32'h0000005A, 1'b0};
        vt[5]  = '{1'b0, 3'd1, 32'h011, 32'h0,        32'h00000000, 1'b1};
        vt[6]  = '{1'b0, 3'd2, 32'h400, 32'h0,        32'h00000000, 1'b1};
        vt[7]  = '{1'b0, 3'd3, 32'h010, 32'h0,        32'h00000000, 1'b1};
        vt[8]  = '{1'b1, 3'd2, 32'h000, 32'hCAFEF00D, 32'h00000000, 1'b0};
        vt[9]  = '{1'b1, 3'd2, 32'h400, 32'h11111111, 32'h00000000, 1'b1};
        vt[10] = '{1'b1, 3'd1, 32'h013, 32'h0000FFFF, 32'h00000000, 1'b1};
        vt[11] = '{1'b1, 3'd3, 32'h010, 32'hFFFFFFFF, 32'h00000000, 1'b1};
        vt[12] = '{1'b0, 3'd2, 32'h000, 32'h0,        32'hCAFEF00D, 1'b0};
        vt[13] = '{1'b0, 3'd2, 32'h010, 32'h0,        32'h5AADBEEF, 1'b0};
        vt[14] = '{1'b1, 3'd1, 32'h012, 32'hAAAA1234, 32'h00000000, 1'b0};
        vt[15] = '{1'b0, 3'd2, 32'h010, 32'h0,        32'h1234BEEF, 1'b0};
        vt[16] = '{1'b0, 3'd1, 32'h012, 32'h0,        32'h00001234, 1'b0};
        vt[17] = '{1'b0, 3'd0, 32'h011, 32'h0,        32'h000000BE, 1'b0};
        vt[18] = '{1'b0, 3'd1, 32'h010, 32'h0,        32'h0000BEEF, 1'b0};
        vt[19] = '{1'b1, 3'd2, 32'h3FC, 32'h0BADCAFE, 32'h00000000, 1'b0};
        vt[20] = '{1'b0, 3'd2, 32'h3FC, 32'h0,        32'h0BADCAFE, 1'b0};
        vt[21] = '{1'b0, 3'd0, 32'h3FF, 32'h0,        32'h0000000B, 1'b0};
        vt[22] = '{1'b0, 3'd2, 32'h3FE, 32'h0,        32'h00000000, 1'b1};

        rstb   = 1'b0;
        addr   = 32'h0;
        size   = 3'd0;
        write  = 1'b0;
        wdata  = 32'h0;
        valid1 = 1'b0;
        valid0 = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {31'h0, ready1}, 32'h0);
        check("rst_err",   {31'h0, err1},   32'h0);
        check("rst_busy",  {31'h0, busy1},  32'h0);
        check("rst_rdata", rdata1,          32'h0);
        @(negedge clk);
        rstb = 1'b1;
        @(posedge clk);
        #1;

        // Vector table on the WAIT=1 instance
        for (int i = 0; i < NV; i++) begin
            do_req(1'b0, vt[i].wr, vt[i].sz, vt[i].a, vt[i].wd, rd, er);
            check($sformatf("v%0d_rdata", i), rd, vt[i].exp_rd);
            check($sformatf("v%0d_err", i), {31'h0, er}, {31'h0, vt[i].exp_err});
            check($sformatf("v%0d_hold", i), rdata1, vt[i].exp_rd);
            check($sformatf("v%0d_idle", i), {31'h0, busy1}, 32'h0);
        end

        // Reset in WAIT abandons the store
        do_req(1'b0, 1'b1, 3'd2, 32'h20, 32'h11112222, rd, er);
        addr = 32'h20; size = 3'd2; write = 1'b1; wdata = 32'h12345678;
        valid1 = 1'b1;
        @(posedge clk);
        #1;
        check("rstwait_busy", {31'h0, busy1}, 32'h1);
        rstb = 1'b0;
        valid1 = 1'b0;
        #2;
        check("rstwait_busy_clr", {31'h0, busy1}, 32'h0);
        check("rstwait_rdata",    rdata1,         32'h0);
        rstb = 1'b1;
        nready = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            if (ready1) nready++;
        end
        check("rstwait_no_ready", 32'(nready), 32'h0);
        do_req(1'b0, 1'b0, 3'd2, 32'h20, 32'h0, rd, er);
        check("rstwait_mem", rd, 32'h11112222);

        // Valid dropped in WAIT gives the same result
        addr = 32'h20; size = 3'd2; write = 1'b1; wdata = 32'h12345678;
        valid1 = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy", {31'h0, busy1}, 32'h1);
        valid1 = 1'b0;
        nready = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            if (ready1) nready++;
        end
        check("abort_no_ready", 32'(nready), 32'h0);
        check("abort_idle", {31'h0, busy1}, 32'h0);
        do_req(1'b0, 1'b0, 3'd2, 32'h20, 32'h0, rd, er);
        check("abort_mem", rd, 32'h11112222);

        // WAIT=0 back-to-back stores, valid re-raised in the IDLE cycle after ready
        addr = 32'h0; size = 3'd2; write = 1'b1; wdata = 32'hA0A0A0A0;
        valid0 = 1'b1;
        @(posedge clk);
        #1;
        check("b2b_ready_a", {31'h0, ready0}, 32'h1);
        check("b2b_err_a",   {31'h0, err0},   32'h0);
        valid0 = 1'b0;
        @(posedge clk);
        #1;
        check("b2b_gap_a", {31'h0, ready0}, 32'h0);
        addr = 32'h4; wdata = 32'hB1B2B3B4;
        valid0 = 1'b1;
        @(posedge clk);
        #1;
        check("b2b_ready_b", {31'h0, ready0}, 32'h1);
        valid0 = 1'b0;
        @(posedge clk);
        #1;
        check("b2b_gap_b", {31'h0, ready0}, 32'h0);
        do_req(1'b1, 1'b0, 3'd2, 32'h0, 32'h0, rd, er);
        check("b2b_mem0", rd, 32'hA0A0A0A0);
        do_req(1'b1, 1'b0, 3'd2, 32'h4, 32'h0, rd, er);
        check("b2b_mem4", rd, 32'hB1B2B3B4);

        // Fibonacci step program: a,b,c,k at 0x100..0x10C, loop while (k-- > 0)
        do_req(1'b0, 1'b1, 3'd2, 32'h100, 32'd1, rd, er);
        do_req(1'b0, 1'b1, 3'd2, 32'h104, 32'd1, rd, er);
        do_req(1'b0, 1'b1, 3'd2, 32'h108, 32'd0, rd, er);
        do_req(1'b0, 1'b1, 3'd2, 32'h10C, 32'd5, rd, er);
        iters = 0;
        for (int it = 0; it < 10; it++) begin
            do_req(1'b0, 1'b0, 3'd2, 32'h10C, 32'h0, fk, er);
            do_req(1'b0, 1'b1, 3'd2, 32'h10C, fk - 32'd1, rd, er);
            if ($signed(fk) <= 0) break;
            iters++;
            do_req(1'b0, 1'b0, 3'd2, 32'h100, 32'h0, fa, er);
            do_req(1'b0, 1'b0, 3'd2, 32'h104, 32'h0, fb, er);
            do_req(1'b0, 1'b1, 3'd2, 32'h108, fa + fb, rd, er);
            do_req(1'b0, 1'b1, 3'd2, 32'h100, fb, rd, er);
            do_req(1'b0, 1'b1, 3'd2, 32'h104, fa + fb, rd, er);
        end
        check("fib_iters", 32'(iters), 32'd5);
        do_req(1'b0, 1'b0, 3'd2, 32'h100, 32'h0, rd, er);
        check("fib_a", rd, 32'd8);
        do_req(1'b0, 1'b0, 3'd2, 32'h104, 32'h0, rd, er);
        check("fib_b", rd, 32'd13);
        do_req(1'b0, 1'b0, 3'd2, 32'h108, 32'h0, rd, er);
        check("fib_c", rd, 32'd13);
        do_req(1'b0, 1'b0, 3'd2, 32'h10C, 32'h0, rd, er);
        check("fib_k", rd, 32'hFFFFFFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_sram_slave.md
BUS_SRAM_SLAVE -- requirements
Module: bus_sram_slave

Interface
REQ-001 SHALL have parameter AW, default 8: word-address width; the memory holds 2^AW 32-bit words.
REQ-002 SHALL have parameter BASE, default 32'h0: byte address of word 0.
REQ-003 SHALL have parameter WAIT, default 1 (0..15): extra wait cycles inserted before ready.
REQ-004 SHALL have port clk  input  1: clock, rising edge.
REQ-005 SHALL have port rstb  input  1: reset, asynchronous, active-low.
REQ-006 SHALL have port addr  input  32: byte address, held stable by the master while valid.
REQ-007 SHALL have port size  input  3: access size; 0=byte, 1=half, 2=word.
REQ-008 SHALL have port valid  input  1: request pending.
REQ-009 SHALL have port write  input  1: 1=store, 0=load.
REQ-010 SHALL have port wdata  input  32: store data, right-justified.
REQ-011 SHALL have port rdata  output  32: load data, right-justified and zero-extended.
REQ-012 SHALL have port ready  output  1: one-cycle completion pulse.
REQ-013 SHALL have port err  output  1: error flag, valid only while ready=1.
REQ-014 SHALL have port busy  output  1: high when the state is not IDLE.

Function
REQ-015 SHALL implement the FSM states IDLE, WAIT and RESP; all outputs SHALL be registered.
REQ-016 IDLE with valid=1 at an edge: SHALL capture addr, size, write and wdata; set the counter to WAIT; go to WAIT, or go directly to RESP when WAIT=0.
REQ-017 WAIT: SHALL decrement the counter each edge; at the edge where the counter reaches 0, SHALL enter RESP.
REQ-018 ready SHALL be 1 exactly for the cycle spent in RESP, then the FSM SHALL return to IDLE. Latency from the first edge sampling valid to ready high is WAIT+1 edges.
REQ-019 A valid sampled low in WAIT (master abort) SHALL return the FSM to IDLE with no write, no ready and no err.
REQ-020 valid=1 in the IDLE cycle right after RESP SHALL be treated as a new request; there is no turnaround cycle.
REQ-021 Error conditions, evaluated on the captured request: size>2; size=1 with addr[0]=1; size=2 with addr[1:0]!=0; addr<BASE; addr-BASE >= 4*2^AW.
REQ-022 On error: err=1 with ready, rdata=0, and memory SHALL NOT be modified.
REQ-023 A store SHALL update memory at the edge entering RESP, using only these byte lanes: size 0 -> lane addr[1:0] gets wdata[7:0]; size 1 -> lanes {addr[1],0} and {addr[1],1} get wdata[15:0]; size 2 -> all lanes get wdata.
REQ-024 A load SHALL set rdata at the edge entering RESP to the word shifted right by 8*addr[1:0], then masked to 8, 16 or 32 bits.
REQ-025 A store response SHALL set rdata=0.
REQ-026 rdata SHALL hold its value outside RESP.
REQ-027 Word index SHALL be (addr-BASE)>>2, truncated to AW bits after the range check.
REQ-028 A load from the same address following a store SHALL return the stored data; there is no read-before-write hazard across requests.

Reset
REQ-029 rstb low SHALL force, asynchronously: state=IDLE, counter=0, ready=0, err=0, busy=0, rdata=0.
REQ-030 Memory array contents SHALL NOT be reset.
REQ-031 Reset during WAIT SHALL abandon the request without performing its write.

Verification
REQ-032 WAIT=1: store word 32'hDEADBEEF at 0x10, then load word 0x10 -> ready 2 edges after valid is sampled; rdata=32'hDEADBEEF; err=0.
REQ-033 Byte store 8'h5A at 0x13, then word load 0x10 -> 32'h5AADBEEF; then byte load 0x13 -> 32'h0000005A.
REQ-034 Half load at 0x11 -> err=1, rdata=0; word load at BASE+4*2^AW -> err=1; size=3 -> err=1; memory unchanged.
REQ-035 WAIT=0, back-to-back word stores to 0x0 and 0x4 with valid re-raised in the cycle after ready -> each ready is a single cycle 1 edge after capture, and both words are written.
REQ-036 rstb pulsed low in WAIT during a store of 32'h12345678 to 0x20 -> ready never asserts, and word 0x20 keeps its prior value; valid dropped in WAIT gives the same result.
REQ-037 Drive the request sequence of a fibonacci_step run (a=1, b=1, k=5 at 0x100..0x10C) -> final memory holds a=8, b=13, c=13, k=-1.
